// File: rtl/adder_serial_if.sv
// Handshake and data bundle for adder_serial: operands in, result/flags out.
// The slave side is the adder itself; the master side is whoever feeds and drains it.
interface adder_serial_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, sub, a, b, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow
  );

  modport slave (
    input  in_valid, sub, a, b, out_ready,
    output in_ready, out_valid, result, carry_out, overflow
  );
endinterface

// File: rtl/adder_serial.sv
// Chunk-serial adder/subtractor: resolves CHUNK bits per clock through a registered
// ripple carry, with valid/ready handshakes on operands and result.
module adder_serial #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  adder_serial_if.slave bus
);
  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("adder_serial: WIDTH must be at least 1");
    end
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("adder_serial: CHUNK must divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             armed;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             carry_out_q;
  logic             overflow_q;
  logic [IDX_W-1:0] idx;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             last_chunk;
  logic             accept;

  // armed keeps in_ready low until the first clock edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= next_state;
      armed <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = CALC;
      CALC:    if (last_chunk) next_state = DONE;
      DONE:    if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE) && armed;
    bus.out_valid = (state == DONE);
  end

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    a_chunk    = op_a[int'(idx) * CHUNK +: CHUNK];
    b_chunk    = op_b[int'(idx) * CHUNK +: CHUNK];
    chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    last_chunk = (idx == IDX_W'(NUM_CHUNKS - 1));
  end

  // Subtraction is a + ~b + 1: the inverted operand and the carry-in of 1 are set at accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a        <= '0;
      op_b        <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      idx         <= '0;
    end else if (accept) begin
      op_a    <= bus.a;
      op_b    <= bus.sub ? ~bus.b : bus.b;
      carry_q <= bus.sub;
      idx     <= '0;
    end else if (state == CALC) begin
      result_q[int'(idx) * CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
      carry_q <= chunk_sum[CHUNK];
      idx     <= last_chunk ? '0 : idx + 1'b1;
      if (last_chunk) begin
        carry_out_q <= chunk_sum[CHUNK];
        overflow_q  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                       (chunk_sum[CHUNK-1] != op_a[WIDTH-1]);
      end
    end
  end

  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
endmodule
